// File: rtl/sipo_word_framer.sv
// sipo_word_framer
//   Collects a qualified serial bit stream into WIDTH-bit words. A frame_start
//   realigns the word boundary. Each completed word goes into a one-deep
//   valid/ready output buffer. A word that completes while the buffer is
//   occupied and not being drained is dropped, and the sticky overflow flag is set.
//
// Ports
//   clock        : single clock, all state updates on posedge
//   rst          : synchronous active-high reset
//   din          : serial data bit, sampled only when din_valid=1
//   din_valid    : qualifies din
//   frame_start  : discards the partial word; din (if valid) becomes bit 0 of a new word
//   word_out     : assembled word (registered, holds last value when consumed)
//   word_valid   : word_out holds an unconsumed word
//   word_ready   : consumer accepts word_out when word_valid && word_ready
//   overflow     : sticky flag, a completed word was dropped
//   overflow_clr : clears overflow (a simultaneous set wins)
//   bit_count    : bits collected in the current partial word
module sipo_word_framer #(
   parameter int WIDTH     = 32,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                     clock,
   input  logic                     rst,
   input  logic                     din,
   input  logic                     din_valid,
   input  logic                     frame_start,
   output logic [WIDTH-1:0]         word_out,
   output logic                     word_valid,
   input  logic                     word_ready,
   output logic                     overflow,
   input  logic                     overflow_clr,
   output logic [$clog2(WIDTH)-1:0] bit_count
);

   localparam int             CW   = $clog2(WIDTH);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} buf_state_t;

   logic [WIDTH-1:0] sh_reg, sh_next;
   logic [WIDTH-1:0] shifted;     // shift register after taking din
   logic [WIDTH-1:0] fresh;       // shift register holding only din (realign)
   logic [CW-1:0]    cnt_reg, cnt_next;
   logic [WIDTH-1:0] word_reg;
   logic             ovf_reg;
   logic             complete;
   logic             load;
   logic             drop;
   buf_state_t       state_reg, state_next;

   // Bit ordering is fixed at elaboration: MSB_FIRST pushes in at the bottom
   // so the first bit ends up at the top, otherwise the reverse.
   generate
      if (MSB_FIRST) begin : g_msb_first
         assign shifted = {sh_reg[WIDTH-2:0], din};
         assign fresh   = {{(WIDTH-1){1'b0}}, din};
      end else begin : g_lsb_first
         assign shifted = {din, sh_reg[WIDTH-1:1]};
         assign fresh   = {din, {(WIDTH-1){1'b0}}};
      end
   endgenerate

   // Bit collection. A realignment overrides completion, so a frame_start
   // arriving on what would have been the last bit never emits a word.
   always_comb begin
      sh_next  = sh_reg;
      cnt_next = cnt_reg;
      complete = 1'b0;
      if (frame_start) begin
         if (din_valid) begin
            sh_next  = fresh;
            cnt_next = CW'(1);
         end else begin
            sh_next  = '0;
            cnt_next = '0;
         end
      end else if (din_valid) begin
         sh_next = shifted;
         if (cnt_reg == LAST) begin
            cnt_next = '0;
            complete = 1'b1;
         end else begin
            cnt_next = cnt_reg + CW'(1);
         end
      end
   end

   // Output buffer. When FULL, a ready in the same cycle as a completion frees
   // the slot just in time for the new word. Without ready, the new word is lost.
   always_comb begin
      state_next = state_reg;
      load       = 1'b0;
      drop       = 1'b0;
      case (state_reg)
         EMPTY: begin
            if (complete) begin
               load       = 1'b1;
               state_next = FULL;
            end
         end
         FULL: begin
            if (complete) begin
               if (word_ready) load = 1'b1;
               else            drop = 1'b1;
            end else if (word_ready) begin
               state_next = EMPTY;
            end
         end
         default: state_next = EMPTY;
      endcase
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         state_reg <= EMPTY;
         sh_reg    <= '0;
         cnt_reg   <= '0;
         word_reg  <= '0;
         ovf_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         sh_reg    <= sh_next;
         cnt_reg   <= cnt_next;
         if (load) word_reg <= sh_next;
         if (drop)              ovf_reg <= 1'b1;
         else if (overflow_clr) ovf_reg <= 1'b0;
      end
   end

   assign word_out   = word_reg;
   assign word_valid = (state_reg == FULL);
   assign overflow   = ovf_reg;
   assign bit_count  = cnt_reg;

endmodule

// File: tb/tb_sipo_word_framer.sv
// Testbench for sipo_word_framer. Two instances, MSB_FIRST=1 and MSB_FIRST=0,
// are driven with identical stimulus. A reference model holds the partial
// word as a queue of received bits and forms words from that list. Expected
// words go into per-instance scoreboards, and a negedge monitor pops and
// compares them on every handshake.
module tb_sipo_word_framer;

   localparam int W = 32;

   logic          clock;
   logic          rst;
   logic          din;
   logic          din_valid;
   logic          frame_start;
   logic          word_ready;
   logic          overflow_clr;
   logic [W-1:0]  word_out_m, word_out_l;
   logic          word_valid_m, word_valid_l;
   logic          overflow_m, overflow_l;
   logic [4:0]    bit_count_m, bit_count_l;

   int checks = 0;
   int errors = 0;

   // reference model state
   bit            bits_q[$];
   bit            model_pending;
   bit            model_ov;
   logic [W-1:0]  exp_m[$];
   logic [W-1:0]  exp_l[$];

   sipo_word_framer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
      .clock(clock), .rst(rst), .din(din), .din_valid(din_valid),
      .frame_start(frame_start), .word_out(word_out_m), .word_valid(word_valid_m),
      .word_ready(word_ready), .overflow(overflow_m), .overflow_clr(overflow_clr),
      .bit_count(bit_count_m));

   sipo_word_framer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
      .clock(clock), .rst(rst), .din(din), .din_valid(din_valid),
      .frame_start(frame_start), .word_out(word_out_l), .word_valid(word_valid_l),
      .word_ready(word_ready), .overflow(overflow_l), .overflow_clr(overflow_clr),
      .bit_count(bit_count_l));

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #1000000;
      $display("FAIL timeout: bench did not finish (got running, want finished)");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   // Word from the bit list: element 0 is the first bit received.
   function automatic logic [W-1:0] form_word(input bit msb_first);
      logic [W-1:0] w;
      w = '0;
      for (int i = 0; i < W; i++) begin
         if (msb_first) w[W-1-i] = bits_q[i];
         else           w[i]     = bits_q[i];
      end
      return w;
   endfunction

   // Applies one clock edge's worth of behaviour to the model.
   task automatic model_step(input bit d, input bit dv, input bit fs,
                             input bit rdy, input bit clr, input bit r);
      bit consume, complete, set_ov;
      if (r) begin
         bits_q.delete();
         exp_m.delete();
         exp_l.delete();
         model_pending = 1'b0;
         model_ov      = 1'b0;
         return;
      end
      consume  = model_pending && rdy;
      complete = 1'b0;
      set_ov   = 1'b0;
      if (fs) begin
         bits_q.delete();
         if (dv) bits_q.push_back(d);
      end else if (dv) begin
         bits_q.push_back(d);
         if (bits_q.size() == W) complete = 1'b1;
      end
      if (complete) begin
         if (!model_pending || rdy) begin
            exp_m.push_back(form_word(1'b1));
            exp_l.push_back(form_word(1'b0));
            model_pending = 1'b1;
         end else begin
            set_ov = 1'b1;
         end
         bits_q.delete();
      end else if (consume) begin
         model_pending = 1'b0;
      end
      if (set_ov)   model_ov = 1'b1;
      else if (clr) model_ov = 1'b0;
   endtask

   // One clock: drive inputs, take the edge, update the model, settle.
   task automatic cyc(input bit d, input bit dv, input bit fs,
                      input bit rdy, input bit clr, input bit r);
      din = d; din_valid = dv; frame_start = fs;
      word_ready = rdy; overflow_clr = clr; rst = r;
      @(posedge clock);
      model_step(d, dv, fs, rdy, clr, r);
      #1;
   endtask

   // Sends w MSB first; the last bit carries last_rdy, optional idle gaps.
   task automatic send_word(input logic [W-1:0] w, input bit rdy, input bit last_rdy,
                            input int gap);
      for (int i = W - 1; i >= 0; i--) begin
         if (gap > 0) repeat ($urandom_range(0, gap)) cyc(1'b0, 1'b0, 1'b0, rdy, 1'b0, 1'b0);
         cyc(w[i], 1'b1, 1'b0, (i == 0) ? last_rdy : rdy, 1'b0, 1'b0);
      end
   endtask

   // Monitor: status outputs against the model every cycle, words against
   // the scoreboard head while valid, pop on handshake.
   always @(negedge clock) begin
      if (!rst) begin
         check("valid_m", 32'(word_valid_m), 32'(model_pending));
         check("valid_l", 32'(word_valid_l), 32'(model_pending));
         check("ovf_m", 32'(overflow_m), 32'(model_ov));
         check("ovf_l", 32'(overflow_l), 32'(model_ov));
         check("bitcnt_m", 32'(bit_count_m), 32'(bits_q.size()));
         check("bitcnt_l", 32'(bit_count_l), 32'(bits_q.size()));
         if (word_valid_m) begin
            if (exp_m.size() == 0) begin
               checks++; errors++;
               $display("FAIL sb_m: got unexpected word %h want none", word_out_m);
            end else begin
               check("word_m", word_out_m, exp_m[0]);
               if (word_ready) void'(exp_m.pop_front());
            end
         end
         if (word_valid_l) begin
            if (exp_l.size() == 0) begin
               checks++; errors++;
               $display("FAIL sb_l: got unexpected word %h want none", word_out_l);
            end else begin
               check("word_l", word_out_l, exp_l[0]);
               if (word_ready) void'(exp_l.pop_front());
            end
         end
      end
   end

   task automatic check_all_zero(input string tag);
      check({tag, "_word_m"}, word_out_m, '0);
      check({tag, "_word_l"}, word_out_l, '0);
      check({tag, "_valid"}, 32'({word_valid_m, word_valid_l}), 32'd0);
      check({tag, "_ovf"}, 32'({overflow_m, overflow_l}), 32'd0);
      check({tag, "_cnt"}, 32'({bit_count_m, bit_count_l}), 32'd0);
   endtask

   initial begin
      logic [W-1:0] wa, wb, wf;
      din = 1'b0; din_valid = 1'b0; frame_start = 1'b0;
      word_ready = 1'b0; overflow_clr = 1'b0; rst = 1'b1;
      model_pending = 1'b0; model_ov = 1'b0;

      // Reset state
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check_all_zero("reset");

      // Tests 1/2: one word, both bit orders
      send_word(32'hA5A5F00F, 1'b1, 1'b1, 0);
      check("t1_valid", 32'(word_valid_m), 32'd1);
      check("t1_word_msb", word_out_m, 32'hA5A5F00F);
      check("t2_word_lsb", word_out_l, 32'hF00FA5A5);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      check("t1_pulse_end", 32'(word_valid_m), 32'd0);
      $display("txn t1/t2 word msb=%h lsb=%h", word_out_m, word_out_l);

      // Test 3: no ready, second word dropped, then clear overflow
      wa = 32'h12345678; wb = 32'h9ABCDEF0;
      send_word(wa, 1'b0, 1'b0, 0);
      send_word(wb, 1'b0, 1'b0, 0);
      check("t3_word_held", word_out_m, wa);
      check("t3_valid", 32'(word_valid_m), 32'd1);
      check("t3_ovf_set", 32'(overflow_m), 32'd1);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check("t3_ovf_clr", 32'(overflow_m), 32'd0);
      check("t3_word_after_clr", word_out_m, wa);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      $display("txn t3 held=%h overflow cleared", wa);

      // Test 4: realign after 10 bits
      for (int i = 0; i < 10; i++) cyc(1'($urandom), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      wf = 32'h3C961E2D;
      cyc(wf[W-1], 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      check("t4_bitcnt_1", 32'(bit_count_m), 32'd1);
      for (int i = W - 2; i >= 0; i--) cyc(wf[i], 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      check("t4_valid", 32'(word_valid_m), 32'd1);
      check("t4_word", word_out_m, wf);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      $display("txn t4 realigned word=%h", wf);

      // Test 5: ready only on word 2's completion cycle
      wa = 32'hDEADBEEF; wb = 32'h0F1E2D3C;
      send_word(wa, 1'b0, 1'b0, 0);
      send_word(wb, 1'b0, 1'b1, 0);
      check("t5_valid", 32'(word_valid_m), 32'd1);
      check("t5_word2", word_out_m, wb);
      check("t5_no_ovf", 32'(overflow_m), 32'd0);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      $display("txn t5 replaced by %h", wb);

      // Test 6: reset with a word pending and 20 bits in flight
      send_word(32'h55AA33CC, 1'b0, 1'b0, 0);
      for (int i = 0; i < 20; i++) cyc(1'($urandom), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check_all_zero("t6_reset");
      wf = 32'hC0FFEE11;
      send_word(wf, 1'b1, 1'b1, 0);
      check("t6_word", word_out_m, wf);
      check("t6_cnt_restart", 32'(bit_count_m), 32'd0);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      $display("txn t6 clean word=%h", wf);

      // Idle gaps: same result as test 1
      send_word(32'hA5A5F00F, 1'b1, 1'b1, 3);
      check("gap_word_msb", word_out_m, 32'hA5A5F00F);
      check("gap_word_lsb", word_out_l, 32'hF00FA5A5);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      $display("txn gaps word=%h", word_out_m);

      // Random traffic
      for (int n = 0; n < 4000; n++) begin
         cyc(1'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 39) == 0),
             ($urandom_range(0, 2) != 0), ($urandom_range(0, 19) == 0),
             ($urandom_range(0, 499) == 0));
      end
      $display("txn random: %0d words left in scoreboard", exp_m.size());
      check("sb_depth_m", 32'(exp_m.size()), 32'(model_pending));
      check("sb_depth_l", 32'(exp_l.size()), 32'(model_pending));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
